// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: request payload, load/store op codes,
// stage state encoding and the misalignment rule.
package mem_access_pkg;

  typedef logic [31:0] word_t;
  typedef logic        bit_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } op_t;

  typedef struct packed {
    bit_t        load;
    bit_t        store;
    word_t       address;
    word_t       wdata;
    logic [3:0]  byte_en;
  } memory_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;
  localparam int unsigned TIMEOUT_W          = $clog2(TIMEOUT_CYCLES_DEF);

  // Halfword ops need an even address, word ops a word-aligned one.
  function automatic bit_t is_misaligned(input op_t op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_misaligned = lo[0];
      OP_LW, OP_SW:         is_misaligned = (lo != 2'b00);
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/halfword of a read word and extends it.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  word_t      rdata_i,
  input  logic [1:0] addr_lo_i,
  input  op_t        op_i,
  output word_t      data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and sign/zero extension.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'd0, byte_sel};
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: one Wishbone-classic single access per request, stalling
// the pipeline until ack, error or timeout, then one DONE writeback cycle.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  memory_t     memory,
  input  op_t         op,
  input  word_t       ex_wdata,
  output word_t       gpr_wdata,
  output logic        stall_req,
  output logic        mem_fault,
  output logic        fault_store,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output word_t       wb_adr_o,
  output word_t       wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  word_t       wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state_q,  state_d;
  logic             cyc_q,    cyc_d;
  logic             store_q,  store_d;
  word_t            adr_q,    adr_d;
  word_t            dat_q,    dat_d;
  logic [3:0]       sel_q,    sel_d;
  op_t              op_q,     op_d;
  logic [1:0]       lo_q,     lo_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  word_t            rdata_q,  rdata_d;
  logic             fault_q,  fault_d;

  logic  req;
  word_t load_data;

  assign req = memory.load | memory.store;

  mem_access_load_align u_load_align (
    .rdata_i   (rdata_q),
    .addr_lo_i (lo_q),
    .op_i      (op_q),
    .data_o    (load_data)
  );

  // Next-state, bus control and writeback selection.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    store_d   = store_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    op_d      = op_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    stall_req = 1'b0;
    gpr_wdata = ex_wdata;

    case (state_q)
      IDLE: begin
        if (req) begin
          stall_req = 1'b1;
          store_d   = memory.store;
          op_d      = op;
          lo_d      = memory.address[1:0];
          if (is_misaligned(op, memory.address[1:0])) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            fault_d = 1'b0;
            adr_d   = {memory.address[31:2], 2'b00};
            sel_d   = memory.byte_en;
            // EX hands over unshifted store data; steer it onto its lanes.
            dat_d   = memory.wdata << {memory.address[1:0], 3'b000};
            cnt_d   = '0;
            cyc_d   = 1'b1;
            state_d = BUS;
          end
        end
      end

      BUS: begin
        stall_req = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (wb_err_i) begin
          fault_d = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else if (wb_ack_i) begin
          rdata_d = wb_dat_i;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (store_q) begin
          gpr_wdata = ex_wdata;
        end else if (fault_q) begin
          gpr_wdata = '0;
        end else begin
          gpr_wdata = load_data;
        end
        // EX advances on this edge, so the held request is not re-issued.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and bus registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      store_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      op_q    <= OP_NOP;
      lo_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      store_q <= store_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = store_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign mem_fault   = (state_q == DONE) & fault_q;
  assign fault_store = (state_q == DONE) & fault_q & store_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a scoreboard of expected completions.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int RSP_ACK  = 0;
  localparam int RSP_ERR  = 1;
  localparam int RSP_BOTH = 2;
  localparam int RSP_NONE = 3;

  typedef struct {
    word_t      gpr;
    logic       fault;
    logic       fstore;
    word_t      adr;
    logic [3:0] sel;
    word_t      dat;
    logic       we;
    int         ncyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  memory_t    memory;
  op_t        op;
  word_t      ex_wdata;
  word_t      gpr_wdata;
  logic       stall_req, mem_fault, fault_store;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  word_t      wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0] wb_sel_o;
  logic       wb_ack_i, wb_err_i;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  mem_access #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .memory      (memory),
    .op          (op),
    .ex_wdata    (ex_wdata),
    .gpr_wdata   (gpr_wdata),
    .stall_req   (stall_req),
    .mem_fault   (mem_fault),
    .fault_store (fault_store),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input word_t gpr, input logic fault, input logic fstore,
                              input word_t adr, input logic [3:0] sel, input word_t dat,
                              input logic we, input int ncyc);
    exp_t e;
    e.gpr = gpr; e.fault = fault; e.fstore = fstore; e.adr = adr;
    e.sel = sel; e.dat = dat; e.we = we; e.ncyc = ncyc;
    return e;
  endfunction

  // Issue one request, answer the bus after ws wait-states, check the completion.
  task automatic run_req(input string tag, input logic ld, input logic st, input word_t addr,
                         input word_t wdata, input logic [3:0] be, input op_t o,
                         input word_t exw, input word_t rdat, input int ws, input int rsp,
                         input exp_t e_in);
    exp_t e;
    int   n;
    int   cyc_cnt;
    logic done;
    sb.push_back(e_in);
    @(posedge clk); #1;
    memory.load = ld; memory.store = st; memory.address = addr;
    memory.wdata = wdata; memory.byte_en = be; op = o; ex_wdata = exw;
    @(negedge clk);
    chk1({tag, ".stall_c0"}, stall_req, 1'b1);
    chk1({tag, ".cyc_c0"}, wb_cyc_o, 1'b0);
    n = 0; cyc_cnt = 0; done = 1'b0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      if (wb_cyc_o && cyc_cnt == ws) begin
        wb_ack_i = (rsp == RSP_ACK) || (rsp == RSP_BOTH);
        wb_err_i = (rsp == RSP_ERR) || (rsp == RSP_BOTH);
        wb_dat_i = rdat;
      end
      @(negedge clk);
      if (wb_cyc_o) begin
        if (cyc_cnt == 0) begin
          e = sb[0];
          chk1 ({tag, ".stb"}, wb_stb_o, 1'b1);
          chk32({tag, ".adr"}, wb_adr_o, e.adr);
          chk32({tag, ".sel"}, 32'(wb_sel_o), 32'(e.sel));
          chk32({tag, ".dat_o"}, wb_dat_o, e.dat);
          chk1 ({tag, ".we"}, wb_we_o, e.we);
        end
        cyc_cnt++;
      end
      if (!stall_req) done = 1'b1;
    end
    chk1({tag, ".done_reached"}, done, 1'b1);
    e = sb.pop_front();
    chk32({tag, ".cyc_cycles"}, 32'(cyc_cnt), 32'(e.ncyc));
    chk32({tag, ".done_cycle"}, 32'(n), 32'(e.ncyc + 1));
    chk32({tag, ".gpr_wdata"}, gpr_wdata, e.gpr);
    chk1 ({tag, ".mem_fault"}, mem_fault, e.fault);
    chk1 ({tag, ".fault_store"}, fault_store, e.fstore);
    @(posedge clk); #1;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    memory = '0; op = OP_NOP;
    @(negedge clk);
    chk1({tag, ".no_reissue"}, wb_cyc_o, 1'b0);
    chk1({tag, ".fault_1cyc"}, mem_fault, 1'b0);
  endtask

  initial begin
    rst = 1'b1; memory = '0; op = OP_NOP; ex_wdata = 32'h0BAD_F00D;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1 ("rst.cyc", wb_cyc_o, 1'b0);
    chk1 ("rst.stb", wb_stb_o, 1'b0);
    chk1 ("rst.we", wb_we_o, 1'b0);
    chk32("rst.adr", wb_adr_o, 32'h0);
    chk32("rst.dat", wb_dat_o, 32'h0);
    chk32("rst.sel", 32'(wb_sel_o), 32'h0);
    chk1 ("rst.fault", mem_fault, 1'b0);
    chk1 ("rst.fstore", fault_store, 1'b0);
    chk1 ("idle.stall", stall_req, 1'b0);
    chk32("idle.passthru", gpr_wdata, 32'h0BAD_F00D);

    run_req("lw", 1, 0, 32'h8000_0004, 32'h0, 4'b1111, OP_LW, 32'h1111_1111,
            32'hDEAD_BEEF, 0, RSP_ACK,
            mk(32'hDEAD_BEEF, 0, 0, 32'h8000_0004, 4'b1111, 32'h0, 0, 1));
    run_req("lb", 1, 0, 32'h8000_0003, 32'h0, 4'b1000, OP_LB, 32'h2222_2222,
            32'h80FF_1234, 0, RSP_ACK,
            mk(32'hFFFF_FF80, 0, 0, 32'h8000_0000, 4'b1000, 32'h0, 0, 1));
    run_req("lbu", 1, 0, 32'h8000_0003, 32'h0, 4'b1000, OP_LBU, 32'h2222_2222,
            32'h80FF_1234, 0, RSP_ACK,
            mk(32'h0000_0080, 0, 0, 32'h8000_0000, 4'b1000, 32'h0, 0, 1));
    run_req("lhu", 1, 0, 32'h8000_0002, 32'h0, 4'b1100, OP_LHU, 32'h3333_3333,
            32'h80FF_1234, 0, RSP_ACK,
            mk(32'h0000_80FF, 0, 0, 32'h8000_0000, 4'b1100, 32'h0, 0, 1));
    run_req("lh", 1, 0, 32'h8000_0002, 32'h0, 4'b1100, OP_LH, 32'h3333_3333,
            32'h80FF_1234, 1, RSP_ACK,
            mk(32'hFFFF_80FF, 0, 0, 32'h8000_0000, 4'b1100, 32'h0, 0, 2));
    run_req("lbu1", 1, 0, 32'h8000_0001, 32'h0, 4'b0010, OP_LBU, 32'h3333_3333,
            32'h80FF_1234, 0, RSP_ACK,
            mk(32'h0000_0012, 0, 0, 32'h8000_0000, 4'b0010, 32'h0, 0, 1));
    run_req("sh", 0, 1, 32'h8000_0002, 32'h0000_ABCD, 4'b1100, OP_SH, 32'h1234_5678,
            32'h0, 3, RSP_ACK,
            mk(32'h1234_5678, 0, 0, 32'h8000_0000, 4'b1100, 32'hABCD_0000, 1, 4));
    run_req("sb", 0, 1, 32'h8000_0001, 32'h0000_00AA, 4'b0010, OP_SB, 32'h5555_5555,
            32'h0, 0, RSP_ACK,
            mk(32'h5555_5555, 0, 0, 32'h8000_0000, 4'b0010, 32'h0000_AA00, 1, 1));
    run_req("lw_mis", 1, 0, 32'h8000_0001, 32'h0, 4'b1111, OP_LW, 32'h4444_4444,
            32'h0, 0, RSP_ACK,
            mk(32'h0, 1, 0, 32'h0, 4'b0, 32'h0, 0, 0));
    run_req("sw_tmo", 0, 1, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111, OP_SW, 32'h6666_6666,
            32'h0, 0, RSP_NONE,
            mk(32'h6666_6666, 1, 1, 32'h8000_0010, 4'b1111, 32'hCAFE_F00D, 1, 8));
    run_req("sw_both", 0, 1, 32'h8000_0014, 32'h0102_0304, 4'b1111, OP_SW, 32'h7777_7777,
            32'h0, 0, RSP_BOTH,
            mk(32'h7777_7777, 1, 1, 32'h8000_0014, 4'b1111, 32'h0102_0304, 1, 1));
    run_req("lw_err", 1, 0, 32'h8000_0018, 32'h0, 4'b1111, OP_LW, 32'h8888_8888,
            32'h1234_5678, 2, RSP_ERR,
            mk(32'h0, 1, 0, 32'h8000_0018, 4'b1111, 32'h0, 0, 3));
    run_req("ldst", 1, 1, 32'h8000_0008, 32'h9ABC_DEF0, 4'b1111, OP_SW, 32'h9999_9999,
            32'h0, 0, RSP_ACK,
            mk(32'h9999_9999, 0, 0, 32'h8000_0008, 4'b1111, 32'h9ABC_DEF0, 1, 1));

    // Reset in the middle of a bus cycle, then a stray ack.
    @(posedge clk); #1;
    memory.load = 1'b0; memory.store = 1'b1; memory.address = 32'h8000_0020;
    memory.wdata = 32'h0; memory.byte_en = 4'b1111; op = OP_SW; ex_wdata = 32'hAAAA_5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rstbus.cyc_before", wb_cyc_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; memory = '0; op = OP_NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1 ("rstbus.cyc", wb_cyc_o, 1'b0);
    chk1 ("rstbus.stb", wb_stb_o, 1'b0);
    chk1 ("rstbus.stall", stall_req, 1'b0);
    @(posedge clk); #1;
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk1 ("lateack.cyc", wb_cyc_o, 1'b0);
    chk1 ("lateack.stall", stall_req, 1'b0);
    chk32("lateack.gpr", gpr_wdata, 32'hAAAA_5555);
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
    @(negedge clk);
    chk1 ("lateack.fault", mem_fault, 1'b0);
    chk1 ("lateack.cyc2", wb_cyc_o, 1'b0);
    chk32("sb.empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage and bus master. Consumes the memory_t request and op_t produced by the execute stage, and performs one Wishbone-classic single read or write per request.
- Stalls the pipeline until the access completes. Aligns and sign/zero-extends load data into gpr_wdata. Passes the ALU result through when there is no memory access.
- Sits between the execute/memory pipeline register and the data bus arbiter.

Parameters:
- TIMEOUT_CYCLES, 256: cycles waited for ack/err after bus assertion before a fault is reported; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- memory  in  memory_t  request from EX: load, store, address, wdata, byte_en
- op  in  op_t  selects load width and sign (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU)
- ex_wdata  in  32  ALU result from EX
- gpr_wdata  out  32  writeback data
- stall_req  out  1  hold upstream pipeline
- mem_fault  out  1  access fault; valid for one cycle in DONE
- fault_store  out  1  fault was on a store
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  bus strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  address, word-aligned (low 2 bits 0)
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte lanes
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error

Behaviour:
- Reset: state IDLE; all wb_*_o = 0; mem_fault = 0; fault_store = 0; timeout counter = 0; captured data register = 0.
- req = memory.load | memory.store. Both set at once is treated as a store.
- Misaligned check, combinational in IDLE. Fault when either holds:
  - LH/LHU/SH with address[0] = 1
  - LW/SW with address[1:0] ≠ 0
- State IDLE:
  - no req: stall_req = 0; gpr_wdata = ex_wdata.
  - req and misaligned: stall_req = 1; no bus cycle; next state DONE with fault set.
  - req and aligned: stall_req = 1; register {address[31:2],2'b00}, byte_en, wdata, store, op; next state BUS.
- State BUS:
  - wb_cyc_o = wb_stb_o = 1 from registers; stall_req = 1; counter increments each cycle.
  - ack_i: capture wb_dat_i; go DONE.
  - err_i: go DONE with fault. err wins over a same-cycle ack.
  - Counter reaches TIMEOUT_CYCLES−1 with no ack/err: drop cyc/stb; go DONE with fault.
  - cyc/stb deassert in the cycle after ack/err/timeout, never in the same cycle.
- State DONE (one cycle):
  - stall_req = 0.
  - gpr_wdata = extracted load data for a successful load; 0 for a faulted load; ex_wdata for a store.
  - mem_fault and fault_store valid this cycle only.
  - Next state is IDLE unconditionally. The still-present request is not re-issued, because EX advances on this edge.
- Load extraction uses the registered address[1:0] and op:
  - LB/LBU: byte at lane addr[1:0].
  - LH/LHU: halfword at addr[1] ? [31:16] : [15:0].
  - LW: full word.
  - Signed ops sign-extend from bit 7/15; unsigned ops zero-extend.
- Latency, aligned access acked in the first BUS cycle: request seen at cycle 0, stb at cycle 1, ack at cycle 1, DONE at cycle 2. Total stall is 2 cycles; each additional wait-state adds 1.
- Reset mid-BUS: cyc/stb = 0 on the next edge and state IDLE. A late ack_i in IDLE is ignored.
- The counter clears on entry to BUS.

Decomposition:
- Shared package (existing defines): memory_t, op_t, word_t, bit_t.
- Add to the package: mem_state_t enum {IDLE, BUS, DONE}; constant TIMEOUT_W = $clog2(TIMEOUT_CYCLES).
- One sub-module: load_align, combinational. Inputs: rdata, addr[1:0], op. Output: the extended word.

Test Plan:
- LW, address 0x80000004, ack on the first BUS cycle with dat_i 0xDEADBEEF:
  - wb_adr_o 0x80000004, sel 1111.
  - DONE at cycle 2, gpr_wdata 0xDEADBEEF.
  - stall_req high for cycles 0–1, low at cycle 2.
- LB at 0x80000003, dat_i 0x80FF1234 → gpr_wdata 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x80000002 → 0x000080FF.
- SH at 0x80000002, rdata2 0x0000ABCD, ack after 3 wait-states:
  - we = 1, sel 1100, dat_o 0xABCD0000.
  - cyc high for 4 cycles; gpr_wdata = ex_wdata in DONE.
- LW at 0x80000001 → no cyc; DONE next cycle with mem_fault = 1, fault_store = 0, gpr_wdata = 0.
- SW with no ack, TIMEOUT_CYCLES = 8:
  - cyc high exactly 8 cycles.
  - mem_fault = 1 and fault_store = 1 in DONE.
  - Same-cycle ack + err → fault.
- Assert rst during BUS → cyc/stb low next cycle, state IDLE. Pulse ack_i afterwards → no output change.
- Back-to-back requests: after DONE, a new request is issued exactly once, with no duplicate bus cycle for the previous request.
